odo_round_key_sequencer: RTL and testbench

ODO_ROUND_KEY_SEQUENCER -- requirements
Module: odo_round_key_sequencer

---
 rtl/odo_round_key_sequencer.sv | 127 ++++++++++++
 tb/tb_odo_round_key_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/odo_round_key_sequencer.sv
// Round-key sequencer: walks periods 0..lim through an external round-key ROM
// and presents the keys in order through a 2-entry valid/ready buffer.
module odo_round_key_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] last_period,
    output logic [3:0] rom_period,
    input  logic [9:0] rom_key,
    output logic [9:0] key_out,
    output logic [3:0] key_period,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t     state;
    logic [3:0] lim;
    logic [3:0] cnt;
    logic [3:0] rom_period_q;
    logic       inflight;
    logic [1:0] count;
    logic [9:0] e0_key, e1_key;
    logic [3:0] e0_per, e1_per;

    logic       xfer;
    logic       issue;
    logic       push;
    logic [1:0] occ;

    always_comb begin
        xfer  = (count != 2'd0) && key_ready;
        occ   = count + {1'b0, inflight};
        issue = (state == RUN) && ((occ < 2'd2) || ((occ == 2'd2) && xfer));
        push  = inflight;
        // The period is shown in the issue cycle itself so the ROM samples it
        // at the closing edge; otherwise the last issued period is held.
        rom_period = issue ? cnt : rom_period_q;
    end

    assign key_valid  = (count != 2'd0);
    assign key_out    = e0_key;
    assign key_period = e0_per;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lim          <= '0;
            cnt          <= '0;
            rom_period_q <= '0;
            inflight     <= 1'b0;
            count        <= '0;
            e0_key       <= '0;
            e1_key       <= '0;
            e0_per       <= '0;
            e1_per       <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lim   <= (last_period > 4'd8) ? 4'd8 : last_period;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == lim) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer && (e0_per == lim)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (issue) begin
                rom_period_q <= cnt;
            end
            inflight <= issue;

            // Entry 0 is the head; it only changes on a pop or when the buffer is empty.
            case ({push, xfer})
                2'b10: begin
                    if (count == 2'd0) begin
                        e0_key <= rom_key;
                        e0_per <= rom_period_q;
                    end else begin
                        e1_key <= rom_key;
                        e1_per <= rom_period_q;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0_key <= e1_key;
                    e0_per <= e1_per;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        e0_key <= rom_key;
                        e0_per <= rom_period_q;
                    end else begin
                        e0_key <= e1_key;
                        e0_per <= e1_per;
                        e1_key <= rom_key;
                        e1_per <= rom_period_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_odo_round_key_sequencer.sv
// Bench for odo_round_key_sequencer: cycle table for a full run plus
// hand-written backpressure, clamp, mid-run reset and ignored-start sequences.
module tb_odo_round_key_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] last_period;
    logic [3:0] rom_period;
    logic [9:0] rom_key;
    logic [9:0] key_out;
    logic [3:0] key_period;
    logic       key_valid;
    logic       key_ready;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [9:0] rom_tbl [16];

    localparam int M_PLAIN = 0;
    localparam int M_BP    = 1;
    localparam int M_RST   = 2;
    localparam int M_PULSE = 3;

    typedef struct {
        logic       rst;
        logic       start;
        logic [3:0] lp;
        logic       ready;
        logic       ev;
        logic [9:0] ek;
        logic [3:0] ep;
        logic       eb;
        logic       ed;
        logic [3:0] erp;
        logic       ck;
    } vec_t;

    vec_t tbl [15];

    odo_round_key_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .last_period(last_period),
        .rom_period (rom_period),
        .rom_key    (rom_key),
        .key_out    (key_out),
        .key_period (key_period),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM returns data the cycle after the edge that samples the period.
    always @(posedge clk) rom_key <= rom_tbl[rom_period];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_seq(input int lp, input int mode, input string nm);
        int n;
        int dones;
        int explim;
        logic rdy;
        logic rst;
        n      = 0;
        dones  = 0;
        explim = (lp > 8) ? 8 : lp;
        for (int c = 0; c < 30; c++) begin
            rst         = (mode == M_RST) && (c == 6);
            rdy         = !((mode == M_BP) && (c >= 4) && (c <= 9));
            reset       = rst;
            start       = (c == 0) || ((mode == M_PULSE) && (c == 2 || c == 5))
                          || ((mode == M_RST) && (c == 8));
            last_period = ((mode == M_PULSE) && (c != 0)) ? 4'd3 : 4'(lp);
            key_ready   = rdy;
            @(negedge clk);
            if ((mode == M_BP) && (c >= 4) && (c <= 9)) begin
                check({nm, " held key"}, key_out, 10'h183);
                check({nm, " stalled rom_period"}, rom_period, 2);
                check({nm, " held valid"}, key_valid, 1);
            end
            if ((mode == M_RST) && (c == 7)) begin
                check({nm, " valid after reset"}, key_valid, 0);
                check({nm, " busy after reset"}, busy, 0);
                check({nm, " rom_period after reset"}, rom_period, 0);
                check({nm, " no done before reset"}, dones, 0);
                n = 0;
            end
            if ((mode == M_RST) && (c == 9)) begin
                check({nm, " restart rom_period"}, rom_period, 0);
                check({nm, " restart busy"}, busy, 1);
            end
            if (done) dones++;
            if (key_valid && rdy && !rst) begin
                check({nm, " key"}, key_out, rom_tbl[4'(n)]);
                check({nm, " period"}, key_period, n);
                n++;
            end
            @(posedge clk);
            #1;
        end
        reset     = 1'b0;
        start     = 1'b0;
        key_ready = 1'b1;
        check({nm, " key count"}, n, explim + 1);
        check({nm, " done pulses"}, dones, 1);
    endtask

    initial begin
        rom_tbl = '{10'h03B, 10'h183, 10'h2CF, 10'h2DC, 10'h246, 10'h0B7, 10'h1D8,
                    10'h2CE, 10'h3F2, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000,
                    10'h000, 10'h000};

        // Rows 0,1: reset held then idle; rows 2..14: cycles 0..12 of a full run.
        for (int i = 0; i < 15; i++) begin
            int c;
            c = i - 2;
            tbl[i].rst   = (i == 0);
            tbl[i].start = (c == 0);
            tbl[i].lp    = 4'd8;
            tbl[i].ready = 1'b1;
            tbl[i].ev    = (c >= 3) && (c <= 11);
            tbl[i].ek    = tbl[i].ev ? rom_tbl[c - 3] : 10'h000;
            tbl[i].ep    = tbl[i].ev ? 4'(c - 3) : 4'd0;
            tbl[i].eb    = (c >= 1) && (c <= 11);
            tbl[i].ed    = (c == 12);
            tbl[i].erp   = (c <= 0) ? 4'd0 : ((c <= 9) ? 4'(c - 1) : 4'd8);
            tbl[i].ck    = tbl[i].ev || (i < 2);
        end

        reset       = 1'b1;
        start       = 1'b0;
        last_period = '0;
        key_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            reset       = tbl[i].rst;
            start       = tbl[i].start;
            last_period = tbl[i].lp;
            key_ready   = tbl[i].ready;
            @(negedge clk);
            check($sformatf("row%0d key_valid", i), key_valid, tbl[i].ev);
            check($sformatf("row%0d busy", i), busy, tbl[i].eb);
            check($sformatf("row%0d done", i), done, tbl[i].ed);
            check($sformatf("row%0d rom_period", i), rom_period, tbl[i].erp);
            if (tbl[i].ck) begin
                check($sformatf("row%0d key_out", i), key_out, tbl[i].ek);
                check($sformatf("row%0d key_period", i), key_period, tbl[i].ep);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        start = 1'b0;

        run_seq(8,  M_BP,    "backpressure");
        run_seq(3,  M_PLAIN, "short");
        run_seq(12, M_PLAIN, "clamped");
        run_seq(8,  M_RST,   "midreset");
        run_seq(8,  M_PULSE, "startpulses");
        run_seq(0,  M_PLAIN, "single");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
